// File: rtl/uhf_sram_apb_responder.sv
// APB3 completer around a byte buffer for the UHF TX/RX SRAM-interface initiators.
// Latency: PREADY rises WAIT_STATES access cycles after the setup edge; read data is registered at setup.
// Backpressure: PREADY is held low while the wait counter runs; PSEL loss mid-transfer aborts the access.
//
// Ports:
//   i_PCLK, i_Reset_all         - clock, synchronous active-high reset
//   i_PADDR/PSEL/PENABLE/PWRITE - APB request (20-bit address, 8-bit data)
//   i_PWDATA, o_PRDATA          - write data in, registered read data out
//   o_PREADY, o_PSLVERR         - completion handshake and out-of-range error response
//   i_clear_status              - pulse clearing the write counter and sticky flags
//   o_write_count               - committed in-range writes, saturating
//   o_addr_error                - sticky: an out-of-range transfer completed
//   o_protocol_error            - sticky: PENABLE without setup, or PSEL dropped mid-transfer
module uhf_sram_apb_responder #(
    parameter int DEPTH       = 8192,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_PCLK,
    input  logic        i_Reset_all,
    input  logic [19:0] i_PADDR,
    input  logic        i_PSEL,
    input  logic        i_PENABLE,
    input  logic        i_PWRITE,
    input  logic [7:0]  i_PWDATA,
    output logic [7:0]  o_PRDATA,
    output logic        o_PREADY,
    output logic        o_PSLVERR,
    input  logic        i_clear_status,
    output logic [13:0] o_write_count,
    output logic        o_addr_error,
    output logic        o_protocol_error
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {s_IDLE, s_ACCESS, s_DONE} state_t;

    state_t      state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic        write_q, write_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        range_err_q, range_err_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [13:0] write_count_q, write_count_d;
    logic        addr_error_q, addr_error_d;
    logic        protocol_error_q, protocol_error_d;

    logic        mem_we;
    logic        cnt_inc;
    logic        aerr_set;
    logic        perr_set;
    logic        in_range;

    logic [7:0]  mem [DEPTH];

    // Range check spans all 20 address bits; the index only uses the low AW bits.
    assign in_range = (i_PADDR < 20'(DEPTH));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        range_err_d = range_err_q;
        wait_cnt_d  = wait_cnt_q;
        prdata_d    = prdata_q;
        pready_d    = pready_q;
        pslverr_d   = pslverr_q;
        mem_we      = 1'b0;
        cnt_inc     = 1'b0;
        aerr_set    = 1'b0;
        perr_set    = 1'b0;

        case (state_q)
            s_IDLE: begin
                if (i_PSEL && !i_PENABLE) begin
                    idx_d       = i_PADDR[AW-1:0];
                    write_d     = i_PWRITE;
                    wdata_d     = i_PWDATA;
                    range_err_d = !in_range;
                    // Read data is captured here so it is stable for the whole access phase.
                    if (!i_PWRITE) begin
                        prdata_d = in_range ? mem[i_PADDR[AW-1:0]] : 8'h00;
                    end
                    wait_cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = !in_range;
                        state_d   = s_DONE;
                    end else begin
                        state_d = s_ACCESS;
                    end
                end else if (i_PSEL && i_PENABLE) begin
                    perr_set = 1'b1;
                end
            end
            s_ACCESS: begin
                if (!i_PSEL) begin
                    perr_set  = 1'b1;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = s_IDLE;
                end else if (i_PENABLE) begin
                    // Raising PREADY on the count-of-1 edge gives exactly WAIT_STATES low cycles.
                    if (wait_cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = range_err_q;
                        state_d   = s_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end
                end
            end
            s_DONE: begin
                if (!i_PSEL) begin
                    perr_set  = 1'b1;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = s_IDLE;
                end else if (i_PENABLE) begin
                    if (range_err_q) begin
                        aerr_set = 1'b1;
                    end else if (write_q) begin
                        mem_we  = 1'b1;
                        cnt_inc = 1'b1;
                    end
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = s_IDLE;
                end
            end
            default: state_d = s_IDLE;
        endcase

        // Clear first, then apply set events so a coincident set wins.
        write_count_d = i_clear_status ? 14'd0 : write_count_q;
        if (cnt_inc && (write_count_d != 14'h3FFF)) begin
            write_count_d = write_count_d + 14'd1;
        end
        addr_error_d     = (addr_error_q && !i_clear_status) || aerr_set;
        protocol_error_d = (protocol_error_q && !i_clear_status) || perr_set;
    end

    always_ff @(posedge i_PCLK) begin
        if (i_Reset_all) begin
            state_q          <= s_IDLE;
            idx_q            <= '0;
            write_q          <= 1'b0;
            wdata_q          <= 8'h00;
            range_err_q      <= 1'b0;
            wait_cnt_q       <= 4'd0;
            prdata_q         <= 8'h00;
            pready_q         <= 1'b0;
            pslverr_q        <= 1'b0;
            write_count_q    <= 14'd0;
            addr_error_q     <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            write_q          <= write_d;
            wdata_q          <= wdata_d;
            range_err_q      <= range_err_d;
            wait_cnt_q       <= wait_cnt_d;
            prdata_q         <= prdata_d;
            pready_q         <= pready_d;
            pslverr_q        <= pslverr_d;
            write_count_q    <= write_count_d;
            addr_error_q     <= addr_error_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    // Storage is never reset; a reset landing on the completion edge cancels the write.
    always_ff @(posedge i_PCLK) begin
        if (mem_we && !i_Reset_all) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign o_PRDATA         = prdata_q;
    assign o_PREADY         = pready_q;
    assign o_PSLVERR        = pslverr_q;
    assign o_write_count    = write_count_q;
    assign o_addr_error     = addr_error_q;
    assign o_protocol_error = protocol_error_q;

endmodule

// File: tb/tb_uhf_sram_apb_responder.sv
module tb_uhf_sram_apb_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] paddr = '0;
    logic        psel = 1'b0;
    logic        pen = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  pwdata = '0;
    logic        clr = 1'b0;
    int          dsel = 0;

    logic [NDUT-1:0] psel_v;
    logic [7:0]  prdata_w [NDUT];
    logic        pready_w [NDUT];
    logic        pslverr_w [NDUT];
    logic [13:0] cnt_w [NDUT];
    logic        aerr_w [NDUT];
    logic        perr_w [NDUT];

    always #5 clk = ~clk;

    // Three instances with wait states 0, 2 and 3 share the bus; PSEL is steered to one.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign psel_v[g] = psel && (dsel == g);
        uhf_sram_apb_responder #(
            .DEPTH(DEPTH),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) u_dut (
            .i_PCLK(clk),
            .i_Reset_all(rst),
            .i_PADDR(paddr),
            .i_PSEL(psel_v[g]),
            .i_PENABLE(pen),
            .i_PWRITE(pwrite),
            .i_PWDATA(pwdata),
            .o_PRDATA(prdata_w[g]),
            .o_PREADY(pready_w[g]),
            .o_PSLVERR(pslverr_w[g]),
            .i_clear_status(clr),
            .o_write_count(cnt_w[g]),
            .o_addr_error(aerr_w[g]),
            .o_protocol_error(perr_w[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-instance byte store plus counters/flags.
    logic [7:0] mdl [int];
    int         m_cnt [NDUT];
    bit         m_aerr [NDUT];
    bit         m_perr [NDUT];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic int key_of(input int d, input logic [19:0] a);
        return d * 32'h0010_0000 + int'(a);
    endfunction

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++) begin
            m_cnt[d] = 0; m_aerr[d] = 1'b0; m_perr[d] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input int d, input string tag);
        chk($sformatf("%s_cnt%0d", tag, d), 32'(cnt_w[d]), 32'(m_cnt[d]));
        chk($sformatf("%s_aerr%0d", tag, d), 32'(aerr_w[d]), 32'(m_aerr[d]));
        chk($sformatf("%s_perr%0d", tag, d), 32'(perr_w[d]), 32'(m_perr[d]));
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0; clr = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        clear_model();
    endtask

    // Issues one transfer and returns at the negedge where PREADY is seen high;
    // the completion edge is the next posedge (taken by the caller's next step).
    task automatic xfer(input int d, input bit wr, input logic [19:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output bit err, output int waits, output bit stable);
        logic [7:0] first_rd;
        bit done;
        @(posedge clk); #1;
        dsel = d; psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        pen = 1'b1;
        waits = 0; stable = 1'b1; done = 1'b0;
        @(negedge clk);
        first_rd = prdata_w[d];
        while (!done) begin
            if (prdata_w[d] !== first_rd) stable = 1'b0;
            if (pready_w[d] === 1'b1) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 40) begin
                    n_checks++; n_errors++;
                    $display("FAIL timeout: PREADY never rose on dut%0d addr 0x%0h", d, a);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        rd = prdata_w[d];
        err = pslverr_w[d];
        if (a >= 20'(DEPTH)) begin
            m_aerr[d] = 1'b1;
        end else if (wr) begin
            mdl[key_of(d, a)] = wd;
            if (m_cnt[d] < 16383) m_cnt[d]++;
        end
    endtask

    typedef struct {
        int          d;
        bit          wr;
        logic [19:0] a;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        bit          exp_err;
        int          exp_waits;
    } vec_t;

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs [13];
        logic [7:0] rd;
        bit err, stable;
        int waits;

        vecs[0]  = '{0, 1'b1, 20'h00010, 8'hA5, 8'h00, 1'b0, 0};
        vecs[1]  = '{0, 1'b0, 20'h00010, 8'h00, 8'hA5, 1'b0, 0};
        vecs[2]  = '{2, 1'b1, 20'h01FFF, 8'h3C, 8'h00, 1'b0, 3};
        vecs[3]  = '{2, 1'b0, 20'h01FFF, 8'h00, 8'h3C, 1'b0, 3};
        vecs[4]  = '{0, 1'b1, 20'h02000, 8'h5A, 8'h00, 1'b1, 0};
        vecs[5]  = '{0, 1'b0, 20'h02000, 8'h00, 8'h00, 1'b1, 0};
        vecs[6]  = '{0, 1'b1, 20'h02010, 8'hEE, 8'h00, 1'b1, 0};
        vecs[7]  = '{0, 1'b0, 20'h00010, 8'h00, 8'hA5, 1'b0, 0};
        vecs[8]  = '{1, 1'b1, 20'h00100, 8'h11, 8'h00, 1'b0, 2};
        vecs[9]  = '{1, 1'b0, 20'h00100, 8'h00, 8'h11, 1'b0, 2};
        vecs[10] = '{0, 1'b0, 20'hFFFFF, 8'h00, 8'h00, 1'b1, 0};
        vecs[11] = '{2, 1'b1, 20'h01FFF, 8'hC3, 8'h00, 1'b0, 3};
        vecs[12] = '{2, 1'b0, 20'h01FFF, 8'h00, 8'hC3, 1'b0, 3};

        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_prdata%0d", d), 32'(prdata_w[d]), 32'h0);
            chk($sformatf("rst_pready%0d", d), 32'(pready_w[d]), 32'h0);
            chk($sformatf("rst_pslverr%0d", d), 32'(pslverr_w[d]), 32'h0);
            chk_status(d, "rst");
        end

        // Directed vectors, issued back to back
        foreach (vecs[i]) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].wd, rd, err, waits, stable);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
            if (!vecs[i].wr) begin
                chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
                chk($sformatf("vec%0d_stable", i), 32'(stable), 32'h1);
            end
        end
        idle();
        @(negedge clk);
        chk("tbl_cnt0", 32'(cnt_w[0]), 32'd1);
        chk("tbl_aerr0", 32'(aerr_w[0]), 32'd1);
        chk("tbl_cnt2", 32'(cnt_w[2]), 32'd2);
        for (int d = 0; d < NDUT; d++) chk_status(d, "tbl");

        // PENABLE without setup on dut0
        @(posedge clk); #1;
        dsel = 0; psel = 1'b1; pen = 1'b1; pwrite = 1'b0; paddr = 20'h00010;
        @(negedge clk);
        chk("noset_pready", 32'(pready_w[0]), 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
        @(negedge clk);
        chk("noset_pready2", 32'(pready_w[0]), 32'h0);
        m_perr[0] = 1'b1;
        for (int d = 0; d < NDUT; d++) chk_status(d, "noset");

        // PSEL dropped mid-write on dut1 (2 wait states)
        xfer(1, 1'b1, 20'h00030, 8'h44, rd, err, waits, stable);
        idle();
        @(posedge clk); #1;
        dsel = 1; psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 20'h00030; pwdata = 8'h99;
        @(posedge clk); #1;
        pen = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        m_perr[1] = 1'b1;
        chk("drop_pready", 32'(pready_w[1]), 32'h0);
        chk_status(1, "drop");
        xfer(1, 1'b0, 20'h00030, 8'h00, rd, err, waits, stable);
        chk("drop_rdata", 32'(rd), 32'h44);
        chk("drop_waits", 32'(waits), 32'd2);
        idle();
        pulse_clear();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) chk_status(d, "clr");

        // Saturation, then clear coinciding with a completion
        for (int i = 0; i < 16385; i++) begin
            xfer(0, 1'b1, 20'h01000, 8'(i), rd, err, waits, stable);
        end
        idle();
        @(negedge clk);
        chk("sat_cnt", 32'(cnt_w[0]), 32'd16383);
        xfer(0, 1'b1, 20'h01001, 8'h5B, rd, err, waits, stable);
        clr = 1'b1;
        idle();
        clear_model();
        m_cnt[0] = 1;
        @(negedge clk);
        chk("clrset_cnt", 32'(cnt_w[0]), 32'd1);
        for (int d = 0; d < NDUT; d++) chk_status(d, "clrset");
        xfer(0, 1'b0, 20'h01000, 8'h00, rd, err, waits, stable);
        chk("sat_rdata", 32'(rd), 32'h00);
        idle();

        // Reset during the access phase of a write on dut1
        xfer(1, 1'b1, 20'h00020, 8'h12, rd, err, waits, stable);
        idle();
        @(posedge clk); #1;
        dsel = 1; psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 20'h00020; pwdata = 8'h77;
        @(posedge clk); #1;
        pen = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        clear_model();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("mrst_prdata%0d", d), 32'(prdata_w[d]), 32'h0);
            chk($sformatf("mrst_pready%0d", d), 32'(pready_w[d]), 32'h0);
            chk($sformatf("mrst_pslverr%0d", d), 32'(pslverr_w[d]), 32'h0);
            chk_status(d, "mrst");
        end
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
        xfer(1, 1'b0, 20'h00020, 8'h00, rd, err, waits, stable);
        chk("mrst_rdata", 32'(rd), 32'h12);
        idle();
        pulse_clear();

        // Randomized traffic against the model
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 60; n++) begin
                logic [19:0] a;
                bit wr;
                logic [7:0] wd;
                bit known;
                logic [7:0] exp_rd;
                if ($urandom_range(0, 7) == 0)
                    a = 20'($urandom_range(DEPTH, 20'hFFFFF));
                else
                    a = 20'($urandom_range(12'h1F0, 12'h1FF));
                wr = 1'($urandom_range(0, 1));
                wd = 8'($urandom);
                known = (a >= 20'(DEPTH)) || mdl.exists(key_of(d, a));
                exp_rd = (a >= 20'(DEPTH)) ? 8'h00 : (known ? mdl[key_of(d, a)] : 8'h00);
                xfer(d, wr, a, wd, rd, err, waits, stable);
                chk($sformatf("rnd%0d_%0d_err", d, n), 32'(err), 32'(a >= 20'(DEPTH)));
                chk($sformatf("rnd%0d_%0d_waits", d, n), 32'(waits), 32'(ws_of(d)));
                if (!wr && known) begin
                    chk($sformatf("rnd%0d_%0d_rdata", d, n), 32'(rd), 32'(exp_rd));
                    chk($sformatf("rnd%0d_%0d_stable", d, n), 32'(stable), 32'h1);
                end
                if ($urandom_range(0, 3) == 0) idle();
            end
            idle();
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) chk_status(d, "rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uhf_sram_apb_responder.md
Name: uhf_sram_apb_responder

Overview:
- APB3 completer (responder) wrapping an on-fabric byte buffer. It answers the UHF TX/RX SRAM-interface initiators with the same 20-bit address and 8-bit data APB bus.
- Used in simulation and as an on-chip replacement for the MSS SRAM slave.
- Inserts a configurable number of wait states, flags out-of-range accesses with PSLVERR, and exposes write/error status to the control FSMs.

Parameters:
- DEPTH, 8192, number of byte locations; valid addresses are 0..DEPTH-1.
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion (0..15).

Ports:
- i_PCLK  in  1  clock; all logic on rising edge.
- i_Reset_all  in  1  synchronous, active-high reset.
- i_PADDR  in  20  APB address.
- i_PSEL  in  1  APB select.
- i_PENABLE  in  1  APB enable.
- i_PWRITE  in  1  1 = write, 0 = read.
- i_PWDATA  in  8  write data.
- o_PRDATA  out  8  read data, registered.
- o_PREADY  out  1  transfer completes on the rising edge where PSEL, PENABLE and PREADY are all 1.
- o_PSLVERR  out  1  error response; valid only while PREADY = 1.
- i_clear_status  in  1  one-cycle pulse that clears the sticky flags and the counter.
- o_write_count  out  14  committed writes; saturates at 16383.
- o_addr_error  out  1  sticky: out-of-range access seen.
- o_protocol_error  out  1  sticky: PENABLE without setup, or PSEL dropped mid-transfer.

Behaviour:
- Reset (checked before all other logic):
  - State goes to s_IDLE.
  - o_PRDATA = 0x00; o_PREADY = 0; o_PSLVERR = 0; o_write_count = 0; o_addr_error = 0; o_protocol_error = 0; wait counter = 0.
  - Memory contents are NOT cleared.
  - Reset mid-transfer aborts the transfer with no memory write.
- FSM states: s_IDLE, s_ACCESS, s_DONE.
- s_IDLE:
  - PSEL=1, PENABLE=0 (setup): latch address, PWRITE and PWDATA; range flag = (PADDR >= DEPTH).
  - Read in range: o_PRDATA <= mem[PADDR[12:0]]. Read out of range: o_PRDATA <= 0x00.
  - Load wait counter with WAIT_STATES.
  - If WAIT_STATES = 0, set o_PREADY = 1 and o_PSLVERR = range flag, then go to s_DONE; otherwise go to s_ACCESS.
  - PSEL=1, PENABLE=1 with no prior setup: set o_protocol_error, stay in s_IDLE, keep PREADY at 0.
- s_ACCESS:
  - Decrement the counter each cycle while PSEL & PENABLE.
  - On the edge where the counter reaches 1, set o_PREADY = 1 and o_PSLVERR = range flag, then go to s_DONE.
  - Result: PREADY is low for exactly WAIT_STATES access cycles.
- s_DONE (PREADY = 1 during this cycle):
  - Completion edge (PSEL & PENABLE): for a write in range, mem[addr] <= latched PWDATA and o_write_count increments (saturating).
  - Any out-of-range completion sets o_addr_error and suppresses the write.
  - Clear o_PREADY and o_PSLVERR, then go to s_IDLE.
- PSEL low in s_ACCESS or s_DONE: abort (no write), set o_protocol_error, clear PREADY and PSLVERR, go to s_IDLE.
- Back-to-back transfers: a setup presented in the cycle right after completion is accepted normally, so there are no dead cycles beyond APB's setup cycle.
- o_PRDATA holds its value from the setup edge until the next read setup. It is therefore stable across the whole access phase, including a mid-cycle (negedge) sample.
- Address decode: the index is PADDR[12:0]; the range check uses all 20 bits.
- i_clear_status clears o_write_count, o_addr_error and o_protocol_error. If a set event lands in the same cycle, the set wins (a count increment from 0 gives 1).
- Write-then-read of the same address returns the new data (the write commits before the next setup edge).

Test Plan:
- Reset, then write 0xA5 to 0x00010 (WAIT_STATES=0) -> PREADY high in the first access cycle, PSLVERR=0, o_write_count=1; a read of 0x00010 returns o_PRDATA=0xA5 throughout the access phase.
- WAIT_STATES=3, read of 0x01FFF -> PREADY low for 3 access cycles, high on the 4th; data equals the last value written there.
- Write 0x5A to 0x02000 (out of range, DEPTH=8192) -> PREADY with PSLVERR=1, memory unchanged, o_addr_error=1, o_write_count unchanged; a read returns 0x00 with PSLVERR=1.
- PENABLE=1 with no setup cycle, then PSEL dropped during a WAIT_STATES=2 write -> o_protocol_error=1, no write, FSM back in s_IDLE; i_clear_status -> all flags and the count are 0.
- 16385 back-to-back writes -> o_write_count saturates at 16383; i_clear_status in the same cycle as a write completion -> count = 1.
- Assert i_Reset_all during s_ACCESS of a write of 0x77 to 0x00020 -> no write (read-back gives the old value); all outputs 0 on the next cycle.
